// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry skid buffer and redirect handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            next_pc_sel_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_cycles
`endif
);

    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drain_target;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] target_aligned;

    // Redirect addresses are always word aligned.
    assign target_aligned = branch_target & ~XLEN'(3);

    // The request address is the PC register itself, so it is stable while waiting.
    assign imem_addr = pc;

    // Fetch FSM with IF/ID register, skid entry and drain target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            drain_target <= RESET_PC;
            imem_req     <= 1'b0;
            if_id_valid  <= 1'b0;
            if_id_pc     <= '0;
            if_id_instr  <= NOP;
            skid_pc      <= '0;
            skid_instr   <= NOP;
        end else begin
            case (state)
                BOOT: begin
                    if (next_pc_sel_taken) begin
                        pc <= target_aligned;
                    end
                    if_id_valid <= 1'b0;
                    imem_req    <= 1'b1;
                    state       <= FETCH;
                end

                FETCH: begin
                    if (next_pc_sel_taken) begin
                        if_id_valid <= 1'b0;
                        if (imem_ack) begin
                            pc <= target_aligned;
                        end else begin
                            drain_target <= target_aligned;
                            imem_req     <= 1'b0;
                            state        <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + PC_STEP;
                        if (stall) begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc;
                            if_id_instr <= imem_rdata;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (next_pc_sel_taken) begin
                        if_id_valid <= 1'b0;
                        pc          <= target_aligned;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= skid_pc;
                        if_id_instr <= skid_instr;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end

                DRAIN: begin
                    // The ack retires the abandoned request; its data is dropped.
                    if (imem_ack) begin
                        pc       <= next_pc_sel_taken ? target_aligned : drain_target;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end else if (next_pc_sel_taken) begin
                        drain_target <= target_aligned;
                    end
                end

                default: begin
                    imem_req <= 1'b0;
                    state    <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic if_id_load;

    // An IF/ID load happens on an unstalled ack in FETCH or a skid drain from HOLD.
    assign if_id_load = !next_pc_sel_taken && !stall &&
                        (((state == FETCH) && imem_ack) || (state == HOLD));

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (if_id_load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (state == HOLD) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by random stimulus, checked against a
// transaction-level reference model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_pc_sel_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .next_pc_sel_taken (next_pc_sel_taken),
        .branch_target     (branch_target),
        .stall             (stall),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instr       (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count       (fetch_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a boot flag, a pending-redirect flag, and a skid queue.
    bit          m_booting;
    bit          m_redirect_pending;
    logic [31:0] m_pending_target;
    logic [63:0] m_skid[$];
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    task automatic model_reset();
        m_booting          = 1'b1;
        m_redirect_pending = 1'b0;
        m_pending_target   = RESET_PC;
        m_skid.delete();
        m_pc      = RESET_PC;
        m_valid   = 1'b0;
        m_ifpc    = '0;
        m_ifinstr = NOP;
        m_fcnt    = '0;
        m_scnt    = '0;
    endtask

    task automatic deliver(input logic [31:0] pc, input logic [31:0] instr);
        m_valid   = 1'b1;
        m_ifpc    = pc;
        m_ifinstr = instr;
        m_fcnt    = m_fcnt + 32'd1;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit redir, input logic [31:0] tgt, input bit stl,
                              input bit ack, input logic [31:0] rd);
        logic [31:0] t;
        logic [63:0] e;
        t = tgt & 32'hFFFF_FFFC;
        if (m_booting) begin
            m_booting = 1'b0;
            m_valid   = 1'b0;
            if (redir) m_pc = t;
        end else if (m_redirect_pending) begin
            if (redir) m_pending_target = t;
            if (ack) begin
                m_redirect_pending = 1'b0;
                m_pc = m_pending_target;
            end
        end else if (m_skid.size() > 0) begin
            m_scnt = m_scnt + 32'd1;
            if (redir) begin
                m_skid.delete();
                m_valid = 1'b0;
                m_pc    = t;
            end else if (!stl) begin
                e = m_skid.pop_front();
                deliver(e[63:32], e[31:0]);
            end
        end else begin
            if (redir) begin
                m_valid = 1'b0;
                if (ack) m_pc = t;
                else begin
                    m_redirect_pending = 1'b1;
                    m_pending_target   = t;
                end
            end else if (ack) begin
                if (stl) m_skid.push_back({m_pc, rd});
                else deliver(m_pc, rd);
                m_pc = m_pc + 32'd4;
            end else if (!stl) begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic bit model_req();
        return !m_booting && !m_redirect_pending && (m_skid.size() == 0) && !rst;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    32'(imem_req),    32'(model_req()));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("if_id_pc",    if_id_pc,         m_ifpc);
        chk("if_id_instr", if_id_instr,      m_ifinstr);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count",  fetch_count,  m_fcnt);
        chk("stall_cycles", stall_cycles, m_scnt);
`endif
    endtask

    // Drive inputs at a falling edge, cross one rising edge, compare at the next falling edge.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit stl,
                        input bit ack, input logic [31:0] rd);
        next_pc_sel_taken = redir;
        branch_target     = tgt;
        stall             = stl;
        imem_ack          = ack;
        imem_rdata        = rd;
        model_step(redir, tgt, stl, ack, rd);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset_instr_nop", if_id_instr, NOP);
        rst = 1'b0;

        // Ack tied high from reset release: 0x0, 0x4, 0x8 back to back.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0000);
        chk("boot_addr0", imem_addr, 32'h0);
        chk("boot_req", 32'(imem_req), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0001);
        chk("seq_addr4", imem_addr, 32'h4);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0002);
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_valid", 32'(if_id_valid), 32'd1);
        chk("seq_ifpc4", if_id_pc, 32'h4);

        // Ack at 0x8 under a 3-cycle stall; acks during the hold are ignored.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hAABB_CCDD);
        chk("hold_prior_instr", if_id_instr, 32'h1111_0002);
        chk("hold_req_low", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_5555);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h6666_6666);
        chk("hold_prior_pc", if_id_pc, 32'h4);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("skid_instr", if_id_instr, 32'hAABB_CCDD);
        chk("skid_pc", if_id_pc, 32'h8);
        chk("skid_addr_c", imem_addr, 32'hC);

        // Redirect with simultaneous ack.
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("redir_ack_valid", 32'(if_id_valid), 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h100);

        // Redirect while ack is pending for two cycles.
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        chk("drain_req_low", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("drain_req_low2", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk("drain_addr", imem_addr, 32'h200);
        chk("drain_no_deliver", 32'(if_id_valid), 32'd0);
        chk("drain_instr_kept", if_id_instr, 32'hAABB_CCDD);

        // Address wrap and target alignment.
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        chk("align_top", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        step(1'b1, 32'h103, 1'b0, 1'b1, 32'h0);
        chk("align_103", imem_addr, 32'h100);

        // Asynchronous reset while a request is outstanding.
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_nop", if_id_instr, NOP);
        chk("async_valid", 32'(if_id_valid), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_req", 32'(imem_req), 32'd1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom(),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6,
                 $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
